poly_eval_seq: RTL

POLY_EVAL_SEQ -- requirements
Module: poly_eval_seq

---
 rtl/poly_eval_seq.sv | 131 +++++++++++++
 1 files changed

// File: rtl/poly_eval_seq.sv
// rtl/poly_eval_seq.sv - serial Horner evaluator y = (a*x + b)*x + c, one shift-add step per cycle
// Build option POLY_EVAL_SAT_EN: wide exact accumulator with saturating result.
module poly_eval_seq (
  input  logic               clock,
  input  logic signed [7:0]  x,
  input  logic signed [15:0] a,
  input  logic signed [15:0] b,
  input  logic signed [15:0] c,
  input  logic               enable,
  input  logic               reset,
  output logic signed [15:0] y,
  output logic               ready,
  output logic               valid
);

`ifdef POLY_EVAL_SAT_EN
  localparam int AW = 34;
`else
  localparam int AW = 16;
`endif

  typedef enum logic [2:0] {IDLE, MUL1, ADDB, MUL2, ADDC, DONE} state_t;

  state_t               state, state_nxt;
  logic signed [7:0]    x_r;
  logic signed [15:0]   a_r, b_r, c_r;
  logic signed [AW-1:0] mcand;
  logic signed [AW-1:0] acc;
  logic signed [AW-1:0] mul_op;
  logic signed [AW-1:0] shifted;
  logic signed [AW-1:0] addend;
  logic signed [AW-1:0] sum;
  logic [2:0]           step;
  logic                 capture;

  // DONE also accepts a waiting request so back-to-back operation sustains one result per 19 cycles.
  assign capture = enable && ((state == IDLE) || (state == DONE));

  function automatic logic signed [15:0] clip(input logic signed [AW-1:0] v);
`ifdef POLY_EVAL_SAT_EN
    if (v > AW'(32'sd32767))
      return 16'sh7fff;
    else if (v < AW'(-32'sd32768))
      return 16'sh8000;
    else
      return v[15:0];
`else
    return v;
`endif
  endfunction

  // Single adder shared by both multiply passes and the two coefficient additions.
  always_comb begin
    mul_op  = (state == MUL1) ? AW'(a_r) : mcand;
    shifted = mul_op <<< step;
    addend  = '0;
    case (state)
      MUL1, MUL2: begin
        if (x_r[step])
          addend = (step == 3'd7) ? -shifted : shifted;
      end
      ADDB:    addend = AW'(b_r);
      ADDC:    addend = AW'(c_r);
      default: addend = '0;
    endcase
    sum = acc + addend;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = MUL1;
      MUL1:    if (step == 3'd7) state_nxt = ADDB;
      ADDB:    state_nxt = MUL2;
      MUL2:    if (step == 3'd7) state_nxt = ADDC;
      ADDC:    state_nxt = DONE;
      DONE:    state_nxt = enable ? MUL1 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready = (state == IDLE);
    valid = (state == DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      x_r   <= '0;
      a_r   <= '0;
      b_r   <= '0;
      c_r   <= '0;
      mcand <= '0;
      acc   <= '0;
      step  <= '0;
      y     <= '0;
    end else if (capture) begin
      x_r   <= x;
      a_r   <= a;
      b_r   <= b;
      c_r   <= c;
      acc   <= '0;
      step  <= '0;
    end else begin
      case (state)
        MUL1, MUL2: begin
          acc  <= sum;
          step <= step + 3'd1;
        end
        // a*x + b becomes the multiplicand of the second pass.
        ADDB: begin
          mcand <= sum;
          acc   <= '0;
        end
        ADDC: begin
          acc <= sum;
          y   <= clip(sum);
        end
        default: ;
      endcase
    end
  end

endmodule
